// File: rtl/dispatch_request_queue.sv
// Dispatch request queue: buffers warp-scheduler requests and routes the head entry to ALU, LSU or special unit.
// Latency: push to m_tvalid_* is 1 cycle; err is registered and pulses the cycle after the offending event.
// Backpressure: the head holds until its unit's ready; s_tready_req drops at DEPTH-1 entries to absorb the in-flight pulse.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of all entries (drops a coincident push)
//   s_tvalid_req      single-cycle push pulse; s_req = {warp_id[102:98], instr[97:35], pred[34:3], alu, lsu, special}
//   s_tready_req      space available toward the scheduler (count <= DEPTH-2)
//   m_tvalid_*/m_tready_*  per-unit handshake for the head entry
//   m_warp_id, m_instr, m_pred  head entry fields, meaningful only while some m_tvalid_* is high
//   count             occupied entries
//   err               0x11 overflow drop, 0x10 malformed flags discarded, one-cycle pulse
module dispatch_request_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_tvalid_req,
    input  logic [102:0]     s_req,
    output logic             s_tready_req,
    output logic             m_tvalid_alu,
    output logic             m_tvalid_lsu,
    output logic             m_tvalid_special,
    input  logic             m_tready_alu,
    input  logic             m_tready_lsu,
    input  logic             m_tready_special,
    output logic [4:0]       m_warp_id,
    output logic [62:0]      m_instr,
    output logic [31:0]      m_pred,
    output logic [PTR_W:0]   count,
    output logic [31:0]      err
);

    localparam logic [PTR_W:0] C_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] C_SLACK = (PTR_W+1)'(DEPTH - 2);
    localparam logic [31:0]    C_ERR_OVF = 32'h0000_0011;
    localparam logic [31:0]    C_ERR_BAD = 32'h0000_0010;

    logic [102:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic [31:0]      r_err;

    logic [102:0]     w_head;
    logic [2:0]       w_flags;
    logic             w_nonempty;
    logic             w_onehot;
    logic             w_bad;
    logic             w_full;
    logic             w_push;
    logic             w_ovf;
    logic             w_hs;
    logic             w_pop;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_flags    = w_head[2:0];
    assign w_nonempty = (r_count != '0);
    assign w_onehot   = (w_flags == 3'b100) || (w_flags == 3'b010) || (w_flags == 3'b001);

    // A malformed head is never presented; it is dropped in the cycle it is seen.
    assign w_bad      = w_nonempty && !w_onehot;

    assign m_tvalid_alu     = w_nonempty && (w_flags == 3'b100);
    assign m_tvalid_lsu     = w_nonempty && (w_flags == 3'b010);
    assign m_tvalid_special = w_nonempty && (w_flags == 3'b001);

    assign m_warp_id = w_head[102:98];
    assign m_instr   = w_head[97:35];
    assign m_pred    = w_head[34:3];

    assign w_hs  = (m_tvalid_alu     && m_tready_alu) ||
                   (m_tvalid_lsu     && m_tready_lsu) ||
                   (m_tvalid_special && m_tready_special);
    assign w_pop = w_hs || w_bad;

    // Fullness is judged on the current count, so a pop in the same cycle
    // never frees a slot for a push into a full queue.
    assign w_full = (r_count == C_FULL);
    assign w_push = s_tvalid_req && !w_full && !flush;
    assign w_ovf  = s_tvalid_req && w_full;

    assign s_tready_req = (r_count <= C_SLACK);
    assign count        = r_count;
    assign err          = r_err;

    // Storage needs no reset; entries are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_err    <= '0;
        end else if (flush) begin
            // A handshake in this cycle counts as delivered; everything is cleared.
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_err    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf) begin
                r_err <= C_ERR_OVF;
            end else if (w_bad) begin
                r_err <= C_ERR_BAD;
            end else begin
                r_err <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_request_queue.sv
// Bench for dispatch_request_queue: directed scenarios plus randomized traffic, checked by a
// queue-based reference model feeding a scoreboard that a negedge monitor drains.
// The driver runs #1 after each rising edge; the monitor compares in the middle of the cycle.
module tb_dispatch_request_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             s_tvalid_req = 1'b0;
    logic [102:0]     s_req = '0;
    logic             s_tready_req;
    logic             m_tvalid_alu, m_tvalid_lsu, m_tvalid_special;
    logic             m_tready_alu = 1'b0, m_tready_lsu = 1'b0, m_tready_special = 1'b0;
    logic [4:0]       m_warp_id;
    logic [62:0]      m_instr;
    logic [31:0]      m_pred;
    logic [PTR_W:0]   count;
    logic [31:0]      err;

    dispatch_request_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_tvalid_req(s_tvalid_req), .s_req(s_req), .s_tready_req(s_tready_req),
        .m_tvalid_alu(m_tvalid_alu), .m_tvalid_lsu(m_tvalid_lsu), .m_tvalid_special(m_tvalid_special),
        .m_tready_alu(m_tready_alu), .m_tready_lsu(m_tready_lsu), .m_tready_special(m_tready_special),
        .m_warp_id(m_warp_id), .m_instr(m_instr), .m_pred(m_pred),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    // Expected visible state for one cycle (after an edge).
    typedef struct {
        logic [31:0] err;
        int          cnt;
        logic        rdy;
        logic [2:0]  vm;
    } rec_t;

    logic [102:0] mq[$];     // reference model contents, head at index 0
    logic [102:0] hs_q[$];   // entries the model expects to be handed to a unit this cycle
    rec_t         rec_q[$];  // expected state, one per cycle
    int           n_chk = 0;
    int           n_pass = 0;
    bit           mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic bit is_onehot(input logic [2:0] f);
        return (f == 3'b100) || (f == 3'b010) || (f == 3'b001);
    endfunction

    function automatic rec_t model_state(input logic [31:0] e);
        rec_t r;
        r.err = e;
        r.cnt = mq.size();
        r.rdy = (mq.size() <= DEPTH - 2);
        r.vm  = (mq.size() > 0 && is_onehot(mq[0][2:0])) ? mq[0][2:0] : 3'b000;
        return r;
    endfunction

    function automatic logic [102:0] mk(input logic [4:0] w, input logic [2:0] f);
        logic [63:0] ins;
        ins = {$urandom, $urandom};
        return {w, ins[62:0], 32'($urandom), f};
    endfunction

    // Drive one cycle of inputs and advance the reference model across the next edge.
    task automatic step(input bit p, input logic [102:0] d, input bit ra, input bit rl,
                        input bit rs, input bit fl);
        bit          full;
        logic [2:0]  hf;
        logic [31:0] e;
        bit          bad;
        @(posedge clk);
        #1;
        s_tvalid_req = p; s_req = d; flush = fl;
        m_tready_alu = ra; m_tready_lsu = rl; m_tready_special = rs;

        full = (mq.size() == DEPTH);
        bad  = 1'b0;
        if (mq.size() > 0) begin
            hf = mq[0][2:0];
            if (!is_onehot(hf)) begin
                bad = 1'b1;
                void'(mq.pop_front());
            end else if ((hf[2] && ra) || (hf[1] && rl) || (hf[0] && rs)) begin
                hs_q.push_back(mq.pop_front());
            end
        end
        if (fl)              e = 32'h0;
        else if (p && full)  e = 32'h11;
        else if (bad)        e = 32'h10;
        else                 e = 32'h0;
        if (fl) mq.delete();
        else if (p && !full) mq.push_back(d);
        rec_q.push_back(model_state(e));
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, '0, r, r, r, 1'b0);
    endtask

    // Monitor: compare the visible state and any handshake against the scoreboard.
    always @(negedge clk) begin
        rec_t         r;
        logic [2:0]   hsm;
        logic [102:0] e;
        if (mon_en) begin
            if (rec_q.size() == 0) begin
                chk("rec_underflow", 64'(1), 64'(0));
            end else begin
                r = rec_q.pop_front();
                chk("count",  64'(count), 64'(r.cnt));
                chk("err",    64'(err),   64'(r.err));
                chk("tready", 64'(s_tready_req), 64'(r.rdy));
                chk("valids", 64'({m_tvalid_alu, m_tvalid_lsu, m_tvalid_special}), 64'(r.vm));
            end
            hsm = {m_tvalid_alu && m_tready_alu, m_tvalid_lsu && m_tready_lsu,
                   m_tvalid_special && m_tready_special};
            if (hsm != 3'b000) begin
                if (hs_q.size() == 0) begin
                    chk("unexpected_handshake", 64'(hsm), 64'(0));
                end else begin
                    e = hs_q.pop_front();
                    chk("hs_unit",  64'(hsm),       64'(e[2:0]));
                    chk("hs_warp",  64'(m_warp_id), 64'(e[102:98]));
                    chk("hs_instr", 64'(m_instr),   64'(e[97:35]));
                    chk("hs_pred",  64'(m_pred),    64'(e[34:3]));
                end
            end
            chk("hs_missing", 64'(hs_q.size()), 64'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit          p, ra, rl, rs, fl;
        logic [2:0]  f;
        int          pp, pr;

        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        // State after the current edge and after the next (idle) edge: both the reset state.
        rec_q.push_back(model_state(32'h0));
        rec_q.push_back(model_state(32'h0));
        mon_en = 1'b1;

        // Single ALU request, popped on its first presented cycle.
        step(1'b1, mk(5'd5, 3'b100), 0, 0, 0, 0);
        step(1'b0, '0, 1, 0, 0, 0);
        idle(2, 0);

        // In-order routing: ALU head blocks LSU and special behind it.
        step(1'b1, mk(5'd3, 3'b100), 0, 0, 0, 0);
        step(1'b1, mk(5'd7, 3'b010), 0, 0, 0, 0);
        step(1'b1, mk(5'd9, 3'b001), 0, 1, 1, 0);
        idle(4, 0);
        idle(5, 1);

        // Fill to DEPTH and overflow once.
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, mk(5'(i), 3'b010), 0, 0, 0, 0);
        idle(2, 0);
        idle(DEPTH + 2, 1);

        // Malformed flag patterns are discarded with err.
        step(1'b1, mk(5'd1, 3'b000), 0, 0, 0, 0);
        step(1'b1, mk(5'd2, 3'b110), 0, 0, 0, 0);
        idle(4, 1);

        // Push and LSU pop in the same cycle at count 4.
        for (int i = 0; i < 4; i++) step(1'b1, mk(5'(10 + i), 3'b010), 0, 0, 0, 0);
        step(1'b1, mk(5'd20, 3'b100), 0, 1, 0, 0);
        idle(7, 1);

        // Flush at count 5 with a coincident ALU handshake and push.
        for (int i = 0; i < 5; i++) step(1'b1, mk(5'(i), 3'b100), 0, 0, 0, 0);
        step(1'b1, mk(5'd30, 3'b100), 1, 0, 0, 1);
        idle(3, 1);

        // Randomized traffic: balanced, then congested.
        for (int ph = 0; ph < 2; ph++) begin
            pp = (ph == 0) ? 50 : 75;
            pr = (ph == 0) ? 50 : 20;
            for (int i = 0; i < 800; i++) begin
                p  = ($urandom_range(0, 99) < pp);
                ra = ($urandom_range(0, 99) < pr);
                rl = ($urandom_range(0, 99) < pr);
                rs = ($urandom_range(0, 99) < pr);
                fl = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 9) < 7) f = 3'(1 << $urandom_range(0, 2));
                else                          f = 3'($urandom_range(0, 7));
                step(p, mk(5'($urandom), f), ra, rl, rs, fl);
            end
        end
        idle(DEPTH + 2, 1);

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < 3; i++) step(1'b1, mk(5'(i), 3'b100), 0, 0, 0, 0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        s_tvalid_req = 1'b0; flush = 1'b0;
        m_tready_alu = 1'b1; m_tready_lsu = 1'b1; m_tready_special = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_count",  64'(count), 64'(0));
        chk("rst_err",    64'(err),   64'(0));
        chk("rst_tready", 64'(s_tready_req), 64'(1));
        chk("rst_valids", 64'({m_tvalid_alu, m_tvalid_lsu, m_tvalid_special}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_count", 64'(count), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dispatch_request_queue.md
Name: dispatch_request_queue

Overview:
- Sits directly downstream of the warp scheduler. Accepts its 103-bit dispatch requests, which arrive as single-cycle valid pulses, and buffers them in a FIFO.
- Routes the head request to exactly one execution unit (ALU, LSU or special) with a per-unit valid/ready handshake.
- Generates the scheduler's request-FIFO ready signal with one slot of slack for the in-flight pulse.

Parameters:
- DEPTH, 8, number of request entries (power of two, >= 4)
- PTR_W, $clog2(DEPTH), pointer width; count width is PTR_W+1

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all entries
- s_tvalid_req  input  1  request push pulse from scheduler
- s_req  input  103  {warp_id[102:98], instr[97:35], pred[34:3], alu[2], lsu[1], special[0]}
- s_tready_req  output  1  space available (drives scheduler m_tready_request_fifo)
- m_tvalid_alu / m_tvalid_lsu / m_tvalid_special  output  1 each  head valid toward unit
- m_tready_alu / m_tready_lsu / m_tready_special  input  1 each  unit accepts
- m_warp_id  output  5  head warp id
- m_instr  output  63  head instruction
- m_pred  output  32  head predicate mask
- count  output  PTR_W+1  occupied entries
- err  output  32  error code, one-cycle pulse

Behaviour:
- Reset (rst_n low, asynchronous):
  - rd/wr pointers and count = 0.
  - err = 0, all m_tvalid_* = 0.
  - s_tready_req = 1.
  - Storage contents are don't-care.
- Storage: registered array of DEPTH x 103.
  - Push writes at the clock edge.
  - Head is visible on the outputs the cycle after the push, so push-to-m_tvalid latency is 1 cycle.
- Outputs m_warp_id, m_instr and m_pred are combinational from the head entry and are valid only when some m_tvalid_* is high.
- Routing, when count > 0, from the head flags {alu, lsu, special}:
  - 100 -> m_tvalid_alu = 1.
  - 010 -> m_tvalid_lsu = 1.
  - 001 -> m_tvalid_special = 1.
  - Any other pattern (000, or more than one bit set) -> no m_tvalid asserted. The entry is discarded that cycle and err = 32'h0000_0010 for one cycle.
- Pop occurs when the asserted m_tvalid_x is high and m_tready_x is high at the edge. Only the head is ever presented; there is no bypass or reordering.
- The head holds stable while its unit's ready is low. Valid is never retracted before the handshake except on flush or reset.
- Push:
  - s_tvalid_req high and count < DEPTH -> write at wr_ptr, advance wr_ptr.
  - s_tvalid_req high and count == DEPTH -> request dropped, err = 32'h0000_0011 for one cycle.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - With count == 0 there is no pop, because the push is not visible until the next cycle.
  - With count == DEPTH, a simultaneous pop does NOT make room for the push; the push is dropped as overflow.
- Pointers wrap modulo DEPTH.
- s_tready_req = (count <= DEPTH-2), combinational. This slack covers the scheduler sampling ready one cycle before its valid pulse.
- err defaults to 0 every cycle. If overflow and a bad flag pattern occur in the same cycle, overflow (0x11) takes priority.
- flush:
  - Next edge sets pointers and count to 0 and drops any push in the same cycle.
  - m_tvalid_* go low the cycle after flush.
  - A handshake coinciding with flush is treated as completed at the unit and is not re-presented.
- Reset mid-operation clears immediately, regardless of outstanding handshakes.

Test Plan:
- Reset release, then push one request with warp_id=5, alu=1 -> next cycle m_tvalid_alu=1, m_warp_id=5, count=1. With m_tready_alu=1 the entry pops; count=0 on the following cycle.
- Push ALU (w3), LSU (w7), SPECIAL (w9); m_tready_alu held 0 for 4 cycles -> m_tvalid_alu stays 1 with m_warp_id=3 and LSU/special valids stay 0 (in-order). On release, pops occur in the order w3, w7, w9.
- Push 7 entries into DEPTH=8 with all readies 0 -> s_tready_req goes 0 once count=7. An 8th push is accepted (count=8). A 9th push gives err=0x11 and count stays 8.
- Push flags 000, then flags 110 -> each is discarded with err=0x10 one cycle after it reaches the head. No m_tvalid is asserted; count returns to 0.
- count=4, push pulse and LSU handshake in the same cycle -> count stays 4. The new entry appears at the tail, confirmed by draining.
- count=5, assert flush -> count=0 and all m_tvalid_*=0 next cycle, s_tready_req=1. A separate test asserts rst_n low mid-drain -> outputs reset asynchronously.
